// File: rtl/nf10_axis_egress_monitor.sv
`default_nettype none
// ============================================================================
// Module      : nf10_axis_egress_monitor
// Description : AXI4-Stream register slice for an output-queue egress port.
//               It forwards beats with one cycle of latency through a two-entry
//               skid buffer. It checks framing (tuser length against counted
//               bytes, tstrb contiguity) and keeps packet, byte and error
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module nf10_axis_egress_monitor #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [C_CNT_WIDTH-1:0]          pkt_count,
    output logic [C_CNT_WIDTH-1:0]          byte_count,
    output logic [15:0]                     len_err_count,
    output logic                            strb_err,
    output logic                            err_pulse
);

    localparam int C_STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int C_BB_W   = $clog2(C_STRB_W + 1);
    localparam int C_BEAT_W = C_AXIS_DATA_WIDTH + C_STRB_W + C_AXIS_TUSER_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    // Datapath storage: main register drives m_axis, skid catches the beat in flight
    logic [C_BEAT_W-1:0]    main_q, main_d, skid_q, skid_d;
    logic                   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic                   s_rdy_q, s_rdy_d;

    // Framing monitor state
    state_t                 state_q, state_d;
    logic [16:0]            acc_q, acc_d;
    logic [15:0]            exp_len_q, exp_len_d;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_q, byte_cnt_q;
    logic [15:0]            len_err_cnt_q;
    logic                   strb_err_q, err_pulse_q;

    logic                   w_in_hs;
    logic [C_BEAT_W-1:0]    w_in_beat;
    logic [C_BB_W-1:0]      w_beat_bytes;
    logic [C_STRB_W-1:0]    w_strb_inc;
    logic [17:0]            w_acc_sum;
    logic [16:0]            w_acc_sat;
    logic                   w_eop;
    logic                   w_len_err;
    logic                   w_strb_viol;

    assign w_in_hs    = s_axis_tvalid & s_rdy_q;
    assign w_in_beat  = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    assign w_strb_inc = s_axis_tstrb + C_STRB_W'(1);
    assign w_acc_sum  = {1'b0, acc_q} + 18'(w_beat_bytes);
    assign w_acc_sat  = w_acc_sum[17] ? 17'h1FFFF : w_acc_sum[16:0];

    // A last beat must be a non-empty run of ones from bit 0 (x & (x+1) == 0);
    // every other beat must be fully populated.
    assign w_strb_viol = w_in_hs & (s_axis_tlast
                         ? ((s_axis_tstrb == '0) || ((s_axis_tstrb & w_strb_inc) != '0))
                         : (s_axis_tstrb != '1));

    assign w_len_err = w_eop & (acc_d != {1'b0, exp_len_d});

    // Byte count of the current beat (popcount of tstrb)
    always_comb begin
        w_beat_bytes = '0;
        for (int i = 0; i < C_STRB_W; i++) begin
            w_beat_bytes = w_beat_bytes + C_BB_W'(s_axis_tstrb[i]);
        end
    end

    // Skid-buffer next state: refill main from skid first to preserve order
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || m_axis_tready) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (w_in_hs) begin
                main_d     = w_in_beat;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (w_in_hs) begin
            skid_d     = w_in_beat;
            skid_vld_d = 1'b1;
        end
    end

    // Ready is registered and reflects whether the skid slot will be free
    assign s_rdy_d = ~skid_vld_d;

    // Datapath registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            s_rdy_q    <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            s_rdy_q    <= s_rdy_d;
        end
    end

    // Framing FSM next state: track expected length and accumulated bytes
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        exp_len_d = exp_len_q;
        w_eop     = 1'b0;
        if (w_in_hs) begin
            case (state_q)
                ST_IDLE: begin
                    exp_len_d = s_axis_tuser[15:0];
                    acc_d     = 17'(w_beat_bytes);
                    if (s_axis_tlast) begin
                        w_eop = 1'b1;
                    end else begin
                        state_d = ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    acc_d = w_acc_sat;
                    if (s_axis_tlast) begin
                        w_eop   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            exp_len_q     <= '0;
            pkt_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            len_err_cnt_q <= '0;
            strb_err_q    <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            exp_len_q   <= exp_len_d;
            strb_err_q  <= strb_err_q | w_strb_viol;
            err_pulse_q <= w_len_err | w_strb_viol;
            if (w_in_hs) begin
                byte_cnt_q <= byte_cnt_q + C_CNT_WIDTH'(w_beat_bytes);
            end
            if (w_eop) begin
                pkt_cnt_q <= pkt_cnt_q + C_CNT_WIDTH'(1);
            end
            if (w_len_err && (len_err_cnt_q != 16'hFFFF)) begin
                len_err_cnt_q <= len_err_cnt_q + 16'd1;
            end
        end
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = main_vld_q;
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = main_q;
    assign pkt_count     = pkt_cnt_q;
    assign byte_count    = byte_cnt_q;
    assign len_err_count = len_err_cnt_q;
    assign strb_err      = strb_err_q;
    assign err_pulse     = err_pulse_q;

endmodule
`default_nettype wire
